alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter n, default 64, operand and result width in bits.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 ReqValid  input  1  a request is present on Opcode/OpA/OpB.
REQ-005 ReqReady  output  1  the sequencer accepts a request this cycle.
REQ-006 Opcode  input  11  LEGv8 opcode field.
REQ-007 OpA, OpB  input  n each  source operands; OpB is already immediate-resolved.
REQ-008 BusA, BusB  output  n each  registered operands driven to the ALU.
REQ-009 ALUCtrl  output  4  registered ALU operation code.
REQ-010 BusW  input  n  ALU result.
REQ-011 Zero  input  1  ALU zero flag.
REQ-012 RspValid  output  1  response fields are valid.
REQ-013 RspReady  input  1  the consumer accepts the response.
REQ-014 Result  output  n  captured BusW.
REQ-015 ZeroOut  output  1  captured Zero.
REQ-016 Branch  output  1  conditional branch taken.
REQ-017 IllegalOp  output  1  the opcode was not decoded.
REQ-018 OpCount  output  16  count of completed responses.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-020 In IDLE, ReqReady SHALL be 1; in every other state it SHALL be 0.
REQ-021 An accept SHALL be ReqValid=1 and ReqReady=1 at a rising edge.
REQ-022 On an accept, the block SHALL latch OpA into BusA, OpB into BusB and the decoded code into ALUCtrl.
REQ-023 On an accept with a legal opcode, the next state SHALL be EXEC.
REQ-024 On an accept with an illegal opcode, the next state SHALL be RESP.
REQ-025 Decode: ADD 10001011000 -> 0010; SUB 11001011000 -> 0110; AND 10001010000 -> 0000; ORR 10101010000 -> 0001.
REQ-026 Decode: LDUR 11111000010 and STUR 11111000000 -> 0010 (address add).
REQ-027 Decode: CBZ Opcode[10:3]=10110100 and CBNZ Opcode[10:3]=10110101 -> 0111 (PassB).
REQ-028 Any other opcode SHALL set IllegalOp=1, ALUCtrl=0111, Result=0, ZeroOut=0 and Branch=0.
REQ-029 EXEC SHALL last exactly one cycle.
REQ-030 At the EXEC exit edge, the block SHALL capture BusW into Result and Zero into ZeroOut.
REQ-031 At the EXEC exit edge, Branch SHALL be set to Zero for CBZ, to ~Zero for CBNZ, and to 0 otherwise.
REQ-032 At the EXEC exit edge, the next state SHALL be RESP.
REQ-033 RspValid SHALL be 1 exactly while in RESP.
REQ-034 All response fields SHALL stay stable until RspValid=1 and RspReady=1 at a rising edge.
REQ-035 On that response handshake, the next state SHALL be IDLE and OpCount SHALL increment.
REQ-036 OpCount SHALL increment for illegal-opcode responses too.
REQ-037 OpCount SHALL wrap from 16'hFFFF to 16'h0000.
REQ-038 Latency for a legal opcode: accept at edge N -> RspValid=1 after edge N+2.
REQ-039 Latency for an illegal opcode: accept at edge N -> RspValid=1 after edge N+1.
REQ-040 Peak throughput SHALL be one operation per 3 cycles, with RspReady held at 1.
REQ-041 ReqValid in EXEC or RESP SHALL be ignored, and the input fields SHALL not be sampled.
REQ-042 RspReady outside RESP SHALL have no effect.
REQ-043 BusA, BusB and ALUCtrl SHALL hold their last values until the next accept.
REQ-044 All outputs SHALL be registered, except ReqReady and RspValid, which are decoded from the state.

Reset
REQ-045 Reset=1 at a rising edge SHALL force state IDLE.
REQ-046 Reset=1 at a rising edge SHALL zero BusA, BusB, ALUCtrl, Result, ZeroOut, Branch, IllegalOp and OpCount.
REQ-047 Reset SHALL take priority over every other event.
REQ-048 Reset in EXEC or RESP SHALL discard the in-flight operation, produce no response and leave OpCount=0.
REQ-049 On the first edge after Reset deasserts, the block SHALL be able to accept a request.

Verification
REQ-050 ADD, OpA=5, OpB=7, ALU model attached, RspReady=1 -> RspValid two edges after the accept; Result=12, ZeroOut=0, ALUCtrl=0010, OpCount=1.
REQ-051 CBZ (Opcode=10110100xxx), OpB=0 -> ALUCtrl=0111, ZeroOut=1, Branch=1; repeat with OpB=3 -> Branch=0.
REQ-052 Opcode=00000000000 -> RspValid one edge after the accept; IllegalOp=1, Result=0, OpCount increments.
REQ-053 RspReady held at 0 for 5 cycles while ReqValid=1 with a new request -> response fields stable, ReqReady=0, second request not accepted until the handshake.
REQ-054 Reset asserted in EXEC -> next cycle IDLE, RspValid=0, all outputs 0, no response.
REQ-055 OpCount preloaded to FFFF via 65535 operations, then one more operation -> OpCount=0000.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Three-state request/response sequencer around an external LEGv8 ALU.
// It decodes the opcode into an ALU control code, launches the operands and captures the result and flags.
module alu_op_sequencer #(
    parameter int n = 64
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic [10:0]  Opcode,
    input  logic [n-1:0] OpA,
    input  logic [n-1:0] OpB,
    output logic [n-1:0] BusA,
    output logic [n-1:0] BusB,
    output logic [3:0]   ALUCtrl,
    input  logic [n-1:0] BusW,
    input  logic         Zero,
    output logic         RspValid,
    input  logic         RspReady,
    output logic [n-1:0] Result,
    output logic         ZeroOut,
    output logic         Branch,
    output logic         IllegalOp,
    output logic [15:0]  OpCount
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic       isCbz;
    logic       isCbnz;

    logic [3:0] decCtrl;
    logic       decIllegal;
    logic       decCbz;
    logic       decCbnz;

    // CBZ/CBNZ only match on the top eight bits; the low three bits belong to the immediate.
    always_comb begin
        decCtrl    = 4'b0111;
        decIllegal = 1'b0;
        decCbz     = 1'b0;
        decCbnz    = 1'b0;
        if (Opcode[10:3] == 8'b10110100) begin
            decCbz = 1'b1;
        end else if (Opcode[10:3] == 8'b10110101) begin
            decCbnz = 1'b1;
        end else begin
            case (Opcode)
                11'b10001011000: decCtrl = 4'b0010;
                11'b11001011000: decCtrl = 4'b0110;
                11'b10001010000: decCtrl = 4'b0000;
                11'b10101010000: decCtrl = 4'b0001;
                11'b11111000010: decCtrl = 4'b0010;
                11'b11111000000: decCtrl = 4'b0010;
                default:         decIllegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            BusA      <= '0;
            BusB      <= '0;
            ALUCtrl   <= '0;
            Result    <= '0;
            ZeroOut   <= 1'b0;
            Branch    <= 1'b0;
            IllegalOp <= 1'b0;
            OpCount   <= '0;
            isCbz     <= 1'b0;
            isCbnz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        BusA      <= OpA;
                        BusB      <= OpB;
                        ALUCtrl   <= decCtrl;
                        IllegalOp <= decIllegal;
                        isCbz     <= decCbz;
                        isCbnz    <= decCbnz;
                        // Illegal opcodes never visit EXEC, so their response fields are forced here.
                        if (decIllegal) begin
                            Result  <= '0;
                            ZeroOut <= 1'b0;
                            Branch  <= 1'b0;
                            state   <= RESP;
                        end else begin
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    Result  <= BusW;
                    ZeroOut <= Zero;
                    Branch  <= (isCbz & Zero) | (isCbnz & ~Zero);
                    state   <= RESP;
                end
                RESP: begin
                    if (RspReady) begin
                        OpCount <= OpCount + 16'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ReqReady = (state == IDLE);
    assign RspValid = (state == RESP);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached to BusA/BusB/ALUCtrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_op_sequencer;

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] ANDO = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] CBNZ = 11'b10110101000;

    logic        CLK = 1'b0;
    logic        Reset, ReqValid, ReqReady, RspValid, RspReady;
    logic [10:0] Opcode;
    logic [63:0] OpA, OpB, BusA, BusB, BusW, Result;
    logic [3:0]  ALUCtrl;
    logic        Zero, ZeroOut, Branch, IllegalOp;
    logic [15:0] OpCount;

    int checks = 0;
    int failures = 0;
    int expCount = 0;

    always #5 CLK = ~CLK;

    alu_op_sequencer #(.n(64)) dut (
        .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .Opcode(Opcode), .OpA(OpA), .OpB(OpB), .BusA(BusA), .BusB(BusB),
        .ALUCtrl(ALUCtrl), .BusW(BusW), .Zero(Zero), .RspValid(RspValid),
        .RspReady(RspReady), .Result(Result), .ZeroOut(ZeroOut), .Branch(Branch),
        .IllegalOp(IllegalOp), .OpCount(OpCount)
    );

    always_comb begin
        case (ALUCtrl)
            4'b0010: BusW = BusA + BusB;
            4'b0110: BusW = BusA - BusB;
            4'b0000: BusW = BusA & BusB;
            4'b0001: BusW = BusA | BusB;
            4'b0111: BusW = BusB;
            default: BusW = '0;
        endcase
        Zero = (BusW == '0);
    end

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic v, input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
        ReqValid = v;
        Opcode   = op;
        OpA      = a;
        OpB      = b;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        checks++;
        if ({ReqReady, RspValid} !== 2'b10) begin
            failures++; $display("FAIL reset_hs got=%b exp=10", {ReqReady, RspValid});
        end
        checks++;
        if ({BusA, BusB, ALUCtrl, Result, ZeroOut, Branch, IllegalOp, OpCount} !== '0) begin
            failures++; $display("FAIL reset_regs got A=%h B=%h ctrl=%h res=%h z=%b br=%b ill=%b cnt=%h exp=all zero",
                                 BusA, BusB, ALUCtrl, Result, ZeroOut, Branch, IllegalOp, OpCount);
        end
    endtask

    task automatic test_add;
        RspReady = 1'b1;
        drive(1'b1, ADD, 64'd5, 64'd7);
        tick();
        drive(1'b0, 11'd0, 64'd0, 64'd0);
        checks++;
        if ({ReqReady, RspValid, BusA, BusB, ALUCtrl} !== {1'b0, 1'b0, 64'd5, 64'd7, 4'b0010}) begin
            failures++; $display("FAIL add_exec got rr=%b rv=%b A=%0d B=%0d ctrl=%b exp rr=0 rv=0 A=5 B=7 ctrl=0010",
                                 ReqReady, RspValid, BusA, BusB, ALUCtrl);
        end
        tick();
        checks++;
        if ({RspValid, Result, ZeroOut, IllegalOp, OpCount} !== {1'b1, 64'd12, 1'b0, 1'b0, 16'(expCount)}) begin
            failures++; $display("FAIL add_resp got rv=%b res=%0d z=%b ill=%b cnt=%0d exp rv=1 res=12 z=0 ill=0 cnt=%0d",
                                 RspValid, Result, ZeroOut, IllegalOp, OpCount, expCount);
        end
        tick();
        expCount++;
        checks++;
        if ({ReqReady, RspValid, OpCount} !== {1'b1, 1'b0, 16'(expCount)}) begin
            failures++; $display("FAIL add_done got rr=%b rv=%b cnt=%0d exp rr=1 rv=0 cnt=%0d",
                                 ReqReady, RspValid, OpCount, expCount);
        end
    endtask

    task automatic test_decode;
        logic [10:0] ops  [5] = '{SUB, ANDO, ORR, LDUR, STUR};
        logic [63:0] aV   [5] = '{64'd10, 64'hC, 64'hC, 64'd100, 64'd200};
        logic [63:0] bV   [5] = '{64'd3, 64'hA, 64'hA, 64'd8, 64'd16};
        logic [3:0]  ctl  [5] = '{4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0010};
        logic [63:0] res  [5] = '{64'd7, 64'h8, 64'hE, 64'd108, 64'd216};
        RspReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], aV[i], bV[i]);
            tick();
            drive(1'b0, 11'd0, 64'd0, 64'd0);
            checks++;
            if (ALUCtrl !== ctl[i]) begin
                failures++; $display("FAIL decode_ctrl[%0d] got=%b exp=%b", i, ALUCtrl, ctl[i]);
            end
            tick();
            checks++;
            if ({RspValid, Result, IllegalOp} !== {1'b1, res[i], 1'b0}) begin
                failures++; $display("FAIL decode_res[%0d] got rv=%b res=%0d ill=%b exp rv=1 res=%0d ill=0",
                                     i, RspValid, Result, IllegalOp, res[i]);
            end
            tick();
            expCount++;
        end
        checks++;
        if (OpCount !== 16'(expCount)) begin
            failures++; $display("FAIL decode_count got=%0d exp=%0d", OpCount, expCount);
        end
    endtask

    task automatic test_branch;
        logic [10:0] ops [3] = '{CBZ, CBZ, CBNZ};
        logic [63:0] bV  [3] = '{64'd0, 64'd3, 64'd3};
        logic        brE [3] = '{1'b1, 1'b0, 1'b1};
        logic        zE  [3] = '{1'b1, 1'b0, 1'b0};
        RspReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], 64'd99, bV[i]);
            tick();
            drive(1'b0, 11'd0, 64'd0, 64'd0);
            checks++;
            if (ALUCtrl !== 4'b0111) begin
                failures++; $display("FAIL branch_ctrl[%0d] got=%b exp=0111", i, ALUCtrl);
            end
            tick();
            checks++;
            if ({RspValid, Result, ZeroOut, Branch} !== {1'b1, bV[i], zE[i], brE[i]}) begin
                failures++; $display("FAIL branch_resp[%0d] got rv=%b res=%0d z=%b br=%b exp rv=1 res=%0d z=%b br=%b",
                                     i, RspValid, Result, ZeroOut, Branch, bV[i], zE[i], brE[i]);
            end
            tick();
            expCount++;
        end
    endtask

    task automatic test_illegal;
        RspReady = 1'b1;
        drive(1'b1, 11'b00000000000, 64'd9, 64'd9);
        tick();
        drive(1'b0, 11'd0, 64'd0, 64'd0);
        checks++;
        if ({RspValid, IllegalOp, Result, ZeroOut, Branch, ALUCtrl, BusA} !==
            {1'b1, 1'b1, 64'd0, 1'b0, 1'b0, 4'b0111, 64'd9}) begin
            failures++; $display("FAIL illegal_resp got rv=%b ill=%b res=%0d z=%b br=%b ctrl=%b A=%0d exp rv=1 ill=1 res=0 z=0 br=0 ctrl=0111 A=9",
                                 RspValid, IllegalOp, Result, ZeroOut, Branch, ALUCtrl, BusA);
        end
        tick();
        expCount++;
        checks++;
        if ({RspValid, OpCount} !== {1'b0, 16'(expCount)}) begin
            failures++; $display("FAIL illegal_count got rv=%b cnt=%0d exp rv=0 cnt=%0d", RspValid, OpCount, expCount);
        end
    endtask

    task automatic test_backpressure;
        RspReady = 1'b0;
        drive(1'b1, ADD, 64'd1, 64'd2);
        tick();
        drive(1'b1, SUB, 64'd50, 64'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({RspValid, ReqReady, Result, BusA, BusB, IllegalOp} !== {1'b1, 1'b0, 64'd3, 64'd1, 64'd2, 1'b0}) begin
                failures++; $display("FAIL hold[%0d] got rv=%b rr=%b res=%0d A=%0d B=%0d ill=%b exp rv=1 rr=0 res=3 A=1 B=2 ill=0",
                                     i, RspValid, ReqReady, Result, BusA, BusB, IllegalOp);
            end
            tick();
        end
        RspReady = 1'b1;
        tick();
        expCount++;
        checks++;
        if ({ReqReady, BusA, OpCount} !== {1'b1, 64'd1, 16'(expCount)}) begin
            failures++; $display("FAIL bp_release got rr=%b A=%0d cnt=%0d exp rr=1 A=1 cnt=%0d", ReqReady, BusA, OpCount, expCount);
        end
        tick();
        drive(1'b0, 11'd0, 64'd0, 64'd0);
        checks++;
        if ({BusA, ALUCtrl, RspValid} !== {64'd50, 4'b0110, 1'b0}) begin
            failures++; $display("FAIL bp_second got A=%0d ctrl=%b rv=%b exp A=50 ctrl=0110 rv=0", BusA, ALUCtrl, RspValid);
        end
        tick();
        checks++;
        if ({RspValid, Result} !== {1'b1, 64'd49}) begin
            failures++; $display("FAIL bp_second_res got rv=%b res=%0d exp rv=1 res=49", RspValid, Result);
        end
        tick();
        expCount++;
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        RspReady = 1'b1;
        drive(1'b1, ORR, 64'd3, 64'd4);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (RspValid === 1'b1) pulses++;
        end
        drive(1'b0, 11'd0, 64'd0, 64'd0);
        expCount += 3;
        checks++;
        if ({pulses, OpCount, ReqReady, Result} !== {32'd3, 16'(expCount), 1'b1, 64'd7}) begin
            failures++; $display("FAIL b2b got pulses=%0d cnt=%0d rr=%b res=%0d exp pulses=3 cnt=%0d rr=1 res=7",
                                 pulses, OpCount, ReqReady, Result, expCount);
        end
    endtask

    task automatic test_reset_exec;
        int stray = 0;
        RspReady = 1'b1;
        drive(1'b1, ADD, 64'd5, 64'd7);
        tick();
        drive(1'b0, 11'd0, 64'd0, 64'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        expCount = 0;
        checks++;
        if ({ReqReady, RspValid, BusA, BusB, ALUCtrl, Result, ZeroOut, Branch, IllegalOp, OpCount} !==
            {1'b1, 1'b0, 64'd0, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            failures++; $display("FAIL rst_exec got rr=%b rv=%b A=%0d B=%0d ctrl=%b res=%0d cnt=%0d exp rr=1 rv=0 rest zero",
                                 ReqReady, RspValid, BusA, BusB, ALUCtrl, Result, OpCount);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (RspValid !== 1'b0) stray++;
        end
        checks++;
        if ({stray, OpCount} !== {32'd0, 16'd0}) begin
            failures++; $display("FAIL rst_noresp got stray=%0d cnt=%0d exp stray=0 cnt=0", stray, OpCount);
        end
        drive(1'b1, ADD, 64'd2, 64'd2);
        tick();
        drive(1'b0, 11'd0, 64'd0, 64'd0);
        checks++;
        if ({BusA, ReqReady} !== {64'd2, 1'b0}) begin
            failures++; $display("FAIL rst_accept got A=%0d rr=%b exp A=2 rr=0", BusA, ReqReady);
        end
        tick();
        tick();
        expCount++;
        checks++;
        if ({Result, OpCount} !== {64'd4, 16'(expCount)}) begin
            failures++; $display("FAIL rst_after got res=%0d cnt=%0d exp res=4 cnt=%0d", Result, OpCount, expCount);
        end
    endtask

    task automatic test_wrap;
        // Preload stands in for 65535 prior operations.
        force dut.OpCount = 16'hFFFF;
        #1;
        release dut.OpCount;
        RspReady = 1'b1;
        drive(1'b1, ADD, 64'd1, 64'd1);
        tick();
        drive(1'b0, 11'd0, 64'd0, 64'd0);
        tick();
        tick();
        checks++;
        if (OpCount !== 16'h0000) begin
            failures++; $display("FAIL wrap got=%h exp=0000", OpCount);
        end
        drive(1'b1, 11'b00000000000, 64'd0, 64'd0);
        tick();
        drive(1'b0, 11'd0, 64'd0, 64'd0);
        tick();
        checks++;
        if (OpCount !== 16'h0001) begin
            failures++; $display("FAIL wrap_next got=%h exp=0001", OpCount);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        RspReady = 1'b0;
        drive(1'b0, 11'd0, 64'd0, 64'd0);
        @(negedge CLK);
        test_reset();
        test_add();
        test_decode();
        test_branch();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_exec();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
